// File: rtl/udp_sweep_ctrl.sv
// udp_sweep_ctrl: exhaustive sweep controller for a small combinational circuit.
//
// The block steps a 4-bit index through 0..15. It drives {a,b,c} = idx[2:0] and d = idx[3].
// After SETTLE_CYC settle cycles it samples the responses of the circuit:
//   - e is sampled for idx 0..7 and builds e_map.
//   - f (e ANDed with d) is sampled for idx 8..15 and builds f_map.
// At the end of the sweep both maps are compared with expect_mask to produce pass.
//
// Parameters:
//   SETTLE_CYC   cycles each input vector is held before sampling (1..15)
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        sweep request, accepted only when idle
//   expect_mask  expected minterm map; bit n is the expected output for {a,b,c} = n
//   a, b, c, d   registered drive to the circuit under test
//   e, f         responses from the circuit under test
//   busy         high while a sweep runs
//   done         one-cycle pulse at sweep completion
//   e_map, f_map captured response maps
//   pass         sweep result, valid from done until the next accepted start
// Optional feature (macro UDP_SWEEP_FIRST_FAIL_EN):
//   fail_valid   set on the first sample that disagrees with expect_mask
//   fail_idx     index of that first disagreeing sample
module udp_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expect_mask,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       e,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic [7:0] e_map,
  output logic [7:0] f_map,
  output logic       pass
`ifdef UDP_SWEEP_FIRST_FAIL_EN
  ,
  output logic       fail_valid,
  output logic [3:0] fail_idx
`endif
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_t;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYC - 1);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic [3:0] idx_nxt;

  assign idx_nxt = idx + 4'd1;

`ifdef UDP_SWEEP_FIRST_FAIL_EN
  logic sample_bit;
  assign sample_bit = idx[3] ? f : e;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdle;
      idx   <= 4'd0;
      cnt   <= 4'd0;
      a     <= 1'b0;
      b     <= 1'b0;
      c     <= 1'b0;
      d     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
      e_map <= 8'h00;
      f_map <= 8'h00;
`ifdef UDP_SWEEP_FIRST_FAIL_EN
      fail_valid <= 1'b0;
      fail_idx   <= 4'd0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            state <= StSettle;
            idx   <= 4'd0;
            cnt   <= 4'd0;
            {a, b, c, d} <= 4'b0000;
            busy  <= 1'b1;
            pass  <= 1'b0;
            e_map <= 8'h00;
            f_map <= 8'h00;
`ifdef UDP_SWEEP_FIRST_FAIL_EN
            fail_valid <= 1'b0;
            fail_idx   <= 4'd0;
`endif
          end
        end
        StSettle: begin
          cnt <= cnt + 4'd1;
          if (cnt == SettleLast) state <= StSample;
        end
        StSample: begin
          // Only the response relevant to the current half of the sweep is captured.
          if (!idx[3]) e_map[idx[2:0]] <= e;
          else         f_map[idx[2:0]] <= f;
`ifdef UDP_SWEEP_FIRST_FAIL_EN
          if (!fail_valid && (sample_bit != expect_mask[idx[2:0]])) begin
            fail_valid <= 1'b1;
            fail_idx   <= idx;
          end
`endif
          if (idx != 4'd15) begin
            idx   <= idx_nxt;
            cnt   <= 4'd0;
            state <= StSettle;
            // Drive changes only when entering SETTLE, so it is stable while sampled.
            {a, b, c, d} <= {idx_nxt[2:0], idx_nxt[3]};
          end else begin
            state <= StDone;
          end
        end
        StDone: begin
          // Maps already include the final sample written on the previous edge.
          pass  <= (e_map == expect_mask) && (f_map == expect_mask);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= StIdle;
          {a, b, c, d} <= 4'b0000;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_sweep_ctrl.sv
// Directed bench for udp_sweep_ctrl.
// The circuit under test is modelled as e = ~c and f = e & d.
// A second instance with SETTLE_CYC = 3 covers the continuously held start case.
module tb_udp_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start3;
  logic [7:0] expect_mask, mask3;
  logic       a, b, c, d, e, f;
  logic       a3, b3, c3, d3, e3, f3;
  logic       busy, done, pass, busy3, done3, pass3;
  logic [7:0] e_map, f_map, e_map3, f_map3;
  logic       f_zero;
`ifdef UDP_SWEEP_FIRST_FAIL_EN
  logic       fail_valid, fail_valid3;
  logic [3:0] fail_idx, fail_idx3;
`endif

  int checks = 0;
  int errors = 0;
  int lat;
  int bad;

  always #5 clk = ~clk;

  // Circuit under test models
  assign e  = ~c;
  assign f  = f_zero ? 1'b0 : (~c & d);
  assign e3 = ~c3;
  assign f3 = ~c3 & d3;

  udp_sweep_ctrl #(.SETTLE_CYC(1)) dut (
    .clk(clk), .rst(rst), .start(start), .expect_mask(expect_mask),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .busy(busy), .done(done), .e_map(e_map), .f_map(f_map), .pass(pass)
`ifdef UDP_SWEEP_FIRST_FAIL_EN
    , .fail_valid(fail_valid), .fail_idx(fail_idx)
`endif
  );

  udp_sweep_ctrl #(.SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .expect_mask(mask3),
    .a(a3), .b(b3), .c(c3), .d(d3), .e(e3), .f(f3),
    .busy(busy3), .done(done3), .e_map(e_map3), .f_map(f_map3), .pass(pass3)
`ifdef UDP_SWEEP_FIRST_FAIL_EN
    , .fail_valid(fail_valid3), .fail_idx(fail_idx3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full SETTLE_CYC=1 sweep with latency, drive sequence and result checks.
  task automatic sweep(input string tag, input logic [7:0] mask, input logic fz,
                       input logic pulse, input logic [7:0] exp_e, input logic [7:0] exp_f,
                       input logic exp_pass, input logic exp_fv, input logic [3:0] exp_fi);
    expect_mask = mask;
    f_zero = fz;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    bad = 0;
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    while (!done && lat < 100) begin
      if (lat <= 31 && {d, a, b, c} != 4'(lat >> 1)) bad++;
      start = (pulse && (lat == 10 || lat == 21)) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd33);
    check({tag, "_drive_seq"}, 32'(bad), 32'd0);
    check({tag, "_e_map"}, 32'(e_map), 32'(exp_e));
    check({tag, "_f_map"}, 32'(f_map), 32'(exp_f));
    check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
`ifdef UDP_SWEEP_FIRST_FAIL_EN
    check({tag, "_fail_valid"}, 32'(fail_valid), 32'(exp_fv));
    check({tag, "_fail_idx"}, 32'(fail_idx), 32'(exp_fi));
`else
    if (exp_fv) bad = bad + 0 * int'(exp_fi);
`endif
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    check({tag, "_drive_zero"}, 32'({a, b, c, d}), 32'd0);
    check({tag, "_e_hold"}, 32'(e_map), 32'(exp_e));
    check({tag, "_pass_hold"}, 32'(pass), 32'(exp_pass));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start3 = 1'b0;
    expect_mask = 8'h55;
    mask3 = 8'h55;
    f_zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_maps", 32'({e_map, f_map}), 32'd0);
    check("rst_drive", 32'({a, b, c, d}), 32'd0);

    sweep("basic", 8'h55, 1'b0, 1'b0, 8'h55, 8'h55, 1'b1, 1'b0, 4'd0);
    sweep("mask_d5", 8'hD5, 1'b0, 1'b0, 8'h55, 8'h55, 1'b0, 1'b1, 4'd7);
    sweep("f_zero", 8'h55, 1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 1'b1, 4'd8);
    sweep("busy_start", 8'h55, 1'b0, 1'b1, 8'h55, 8'h55, 1'b1, 1'b0, 4'd0);

    // Reset mid-sweep at idx 5
    expect_mask = 8'h55;
    f_zero = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_drive_idx5", 32'({d, a, b, c}), 32'd5);
    check("mid_e_map", 32'(e_map), 32'h15);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_pass", 32'(pass), 32'd0);
    check("midrst_maps", 32'({e_map, f_map}), 32'd0);
    check("midrst_drive", 32'({a, b, c, d}), 32'd0);
`ifdef UDP_SWEEP_FIRST_FAIL_EN
    check("midrst_fail", 32'({fail_valid, fail_idx}), 32'd0);
`endif
    sweep("after_rst", 8'h55, 1'b0, 1'b0, 8'h55, 8'h55, 1'b1, 1'b0, 4'd0);

    // SETTLE_CYC=3 with start held high
    @(negedge clk) start3 = 1'b1;
    @(posedge clk);
    #1 lat = 0;
    while (!done3 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("s3_latency", 32'(lat), 32'd65);
    check("s3_pass1", 32'(pass3), 32'd1);
    check("s3_maps1", 32'({e_map3, f_map3}), 32'h5555);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done3 && lat < 200);
    check("s3_period", 32'(lat), 32'd66);
    check("s3_pass2", 32'(pass3), 32'd1);
    start3 = 1'b0;
    @(posedge clk);
    #1;
    check("s3_release_idle", 32'(busy3), 32'd0);
    check("s3_done_pulse", 32'(done3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
